// File: rtl/step_response_monitor.sv
// Step response measurement. Watches the filter output after a step and
// reports rise time, peak, overshoot and settling time.
module step_response_monitor #(
  parameter int WIDTH       = 18,
  parameter int CNT_W       = 16,
  parameter int SETTLE_HOLD = 16,
  parameter int MAX_CYCLES  = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] v_in,
  input  logic [WIDTH-1:0] v_final,
  input  logic [WIDTH-1:0] th_lo,
  input  logic [WIDTH-1:0] th_hi,
  input  logic [WIDTH-2:0] band,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] t_rise,
  output logic [CNT_W-1:0] t_settle,
  output logic [WIDTH-1:0] peak,
  output logic [WIDTH:0]   overshoot
);

  typedef enum logic [2:0] {IDLE, WAIT_LO, WAIT_HI, SETTLE, FINISH} state_t;

  localparam logic [CNT_W-1:0] HOLD = CNT_W'(SETTLE_HOLD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);

  state_t state, state_n;

  logic [CNT_W-1:0] idx, run_len, run_start, t_lo_idx, t_hi_idx;
  logic [CNT_W-1:0] lo_n, hi_n;
  logic             measuring, accept, ge_lo, ge_hi, eval, in_band;
  logic             settled, expire;
  logic [WIDTH-1:0] peak_n;
  logic signed [WIDTH:0] dev, dev_abs, os;

  assign measuring = (state == WAIT_LO) || (state == WAIT_HI) || (state == SETTLE);
  assign busy      = measuring;
  // A sample arriving with start belongs to the aborted run, so drop it.
  assign accept    = measuring && in_valid && !start;

  assign ge_lo = $signed(v_in) >= $signed(th_lo);
  assign ge_hi = $signed(v_in) >= $signed(th_hi);

  // The high-crossing sample is already judged for settling.
  assign eval = (state == SETTLE) ||
                (state == WAIT_HI && ge_hi) ||
                (state == WAIT_LO && ge_lo && ge_hi);

  assign lo_n = (state == WAIT_LO) ? idx : t_lo_idx;
  assign hi_n = (state == SETTLE)  ? t_hi_idx : idx;

  // Deviation is taken one bit wider so it can never wrap.
  assign dev     = $signed({v_in[WIDTH-1], v_in}) - $signed({v_final[WIDTH-1], v_final});
  assign dev_abs = dev[WIDTH] ? -dev : dev;
  assign in_band = $unsigned(dev_abs) <= {2'b00, band};

  assign settled = accept && eval && in_band && ((run_len + 1'b1) == HOLD);
  assign expire  = accept && !settled && (idx == LAST);

  assign peak_n = ($signed(v_in) > $signed(peak)) ? v_in : peak;
  assign os     = $signed({peak_n[WIDTH-1], peak_n}) - $signed({v_final[WIDTH-1], v_final});

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state: start always wins, otherwise advance on accepted samples.
  always_comb begin
    state_n = state;
    if (start) begin
      state_n = WAIT_LO;
    end else if (accept) begin
      if (settled || expire) begin
        state_n = FINISH;
      end else begin
        case (state)
          WAIT_LO: if (ge_lo) state_n = ge_hi ? SETTLE : WAIT_HI;
          WAIT_HI: if (ge_hi) state_n = SETTLE;
          default: ;
        endcase
      end
    end
  end

  // Measurement datapath and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      run_len   <= '0;
      run_start <= '0;
      t_lo_idx  <= '0;
      t_hi_idx  <= '0;
      peak      <= '0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      t_rise    <= '0;
      t_settle  <= '0;
      overshoot <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        idx       <= '0;
        run_len   <= '0;
        run_start <= '0;
        t_lo_idx  <= '0;
        t_hi_idx  <= '0;
        peak      <= {1'b1, {(WIDTH-1){1'b0}}};
        timeout   <= 1'b0;
        t_rise    <= '0;
        t_settle  <= '0;
        overshoot <= '0;
      end else if (accept) begin
        idx  <= idx + 1'b1;
        peak <= peak_n;
        if (state == WAIT_LO && ge_lo) t_lo_idx <= idx;
        if (state != SETTLE && eval)   t_hi_idx <= idx;
        if (eval) begin
          run_len <= in_band ? run_len + 1'b1 : '0;
          if (in_band && run_len == '0) run_start <= idx;
        end
        if (settled) begin
          done      <= 1'b1;
          t_settle  <= (run_len == '0) ? idx : run_start;
          t_rise    <= hi_n - lo_n;
          overshoot <= os[WIDTH] ? '0 : $unsigned(os);
        end else if (expire) begin
          done      <= 1'b1;
          timeout   <= 1'b1;
          t_rise    <= '1;
          t_settle  <= '1;
          overshoot <= os[WIDTH] ? '0 : $unsigned(os);
        end
      end
    end
  end

endmodule

// File: tb/tb_step_response_monitor.sv
// Bench for step_response_monitor: directed scenarios plus randomized
// step responses checked against a window-search reference model.
module tb_step_response_monitor;
  localparam int W = 16, CW = 16, HOLD = 4, MAXC = 64;
  localparam int VF = 1000, TLO = 100, THI = 900, BAND = 20;

  logic          clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [W-1:0]  v_in = '0;
  logic [W-1:0]  v_final = 16'd1000, th_lo = 16'd100, th_hi = 16'd900;
  logic [W-2:0]  band = 15'd20;
  logic          busy, done, timeout;
  logic [CW-1:0] t_rise, t_settle;
  logic [W-1:0]  peak;
  logic [W:0]    overshoot;

  int checks = 0, failures = 0;
  int smp[MAXC];
  int acc_done;
  bit got_done, busy_at_done, done_next, busy_after_start;

  always #5 clk = ~clk;

  step_response_monitor #(.WIDTH(W), .CNT_W(CW), .SETTLE_HOLD(HOLD), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .v_in(v_in),
    .v_final(v_final), .th_lo(th_lo), .th_hi(th_hi), .band(band),
    .busy(busy), .done(done), .timeout(timeout), .t_rise(t_rise),
    .t_settle(t_settle), .peak(peak), .overshoot(overshoot)
  );

  // Reference: first lo crossing, first hi crossing at/after it, then the
  // earliest window of HOLD consecutive in-band samples starting at hi.
  task automatic model(output int e, output int lo, output int hi, output int st,
                       output bit to, output int pk);
    bit ok;
    lo = -1; hi = -1; st = -1; to = 1; e = MAXC - 1;
    for (int k = 0; k < MAXC; k++) if (smp[k] >= TLO) begin lo = k; break; end
    if (lo >= 0) for (int k = lo; k < MAXC; k++) if (smp[k] >= THI) begin hi = k; break; end
    if (hi >= 0) for (int s = hi; s + HOLD <= MAXC; s++) begin
      ok = 1;
      for (int j = s; j < s + HOLD; j++)
        if (smp[j] - VF > BAND || VF - smp[j] > BAND) ok = 0;
      if (ok) begin st = s; e = s + HOLD - 1; to = 0; break; end
    end
    pk = smp[0];
    for (int k = 1; k <= e; k++) if (smp[k] > pk) pk = smp[k];
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < MAXC; k++) smp[k] = (100 * k > 1000) ? 1000 : 100 * k;
  endtask

  // Start a measurement and feed smp[] until done or the cycle budget runs out.
  // gmode: 0 = no gaps, 1 = every other cycle idle, 2 = random idles.
  task automatic run(input int gmode, input bit collide);
    int acc, cyc;
    acc = 0; cyc = 0; got_done = 0; acc_done = -1;
    @(negedge clk); start = 1; in_valid = 0;
    if (collide) begin
      @(negedge clk); start = 1; in_valid = 1; v_in = 16'(30000);
    end
    @(negedge clk); start = 0; in_valid = 0;
    busy_after_start = busy;
    while (!got_done && cyc < 400) begin
      in_valid = (acc < MAXC) && !(gmode == 1 && cyc % 2 == 1)
                 && !(gmode == 2 && $urandom_range(0, 2) == 0);
      v_in = (acc < MAXC) ? 16'(smp[acc]) : '0;
      @(posedge clk);
      if (in_valid) acc++;
      @(negedge clk);
      cyc++;
      if (done) begin got_done = 1; acc_done = acc; busy_at_done = busy; end
    end
    in_valid = 0;
    if (!got_done) begin
      checks++; failures++;
      $display("FAIL done_timeout got=no_done exp=done within 400 cycles");
    end
    @(negedge clk); done_next = done;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({busy, done, timeout, t_rise, t_settle, peak, overshoot} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {busy, done, timeout, t_rise, t_settle, peak, overshoot});
    end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_ramp(input string nm, input int gmode, input bit collide);
    fill_ramp();
    run(gmode, collide);
    checks++; if (busy_after_start !== 1'b1) begin failures++; $display("FAIL %s_busy_rise got=%b exp=1", nm, busy_after_start); end
    checks++; if (acc_done != 14) begin failures++; $display("FAIL %s_done_at got=%0d exp=14", nm, acc_done); end
    checks++; if (t_rise !== 16'd8) begin failures++; $display("FAIL %s_t_rise got=%0d exp=8", nm, t_rise); end
    checks++; if (t_settle !== 16'd10) begin failures++; $display("FAIL %s_t_settle got=%0d exp=10", nm, t_settle); end
    checks++; if (peak !== 16'd1000 || overshoot !== 17'd0) begin failures++; $display("FAIL %s_peak_os got=%0d/%0d exp=1000/0", nm, peak, overshoot); end
    checks++; if (timeout !== 1'b0 || busy_at_done !== 1'b0 || done_next !== 1'b0) begin
      failures++; $display("FAIL %s_flags got=to%b busy%b dnext%b exp=0/0/0", nm, timeout, busy_at_done, done_next);
    end
  endtask

  task automatic test_overshoot();
    int v[8] = '{0, 500, 1100, 1050, 1010, 995, 1000, 1000};
    for (int k = 0; k < MAXC; k++) smp[k] = (k < 8) ? v[k] : 1000;
    run(0, 0);
    checks++; if (acc_done != 8) begin failures++; $display("FAIL os_done_at got=%0d exp=8", acc_done); end
    checks++; if (t_rise !== 16'd1 || t_settle !== 16'd4) begin failures++; $display("FAIL os_times got=%0d/%0d exp=1/4", t_rise, t_settle); end
    checks++; if (peak !== 16'd1100 || overshoot !== 17'd100) begin failures++; $display("FAIL os_peak got=%0d/%0d exp=1100/100", peak, overshoot); end
  endtask

  task automatic test_band_reentry();
    int v[6] = '{0, 950, 1000, 1000, 1000, 1030};
    for (int k = 0; k < MAXC; k++) smp[k] = (k < 6) ? v[k] : 1000;
    run(0, 0);
    checks++; if (acc_done != 10) begin failures++; $display("FAIL reentry_done_at got=%0d exp=10", acc_done); end
    checks++; if (t_rise !== 16'd0 || t_settle !== 16'd6) begin failures++; $display("FAIL reentry_times got=%0d/%0d exp=0/6", t_rise, t_settle); end
  endtask

  task automatic test_timeout();
    for (int k = 0; k < MAXC; k++) smp[k] = 0;
    run(0, 0);
    checks++; if (acc_done != 64) begin failures++; $display("FAIL to_done_at got=%0d exp=64", acc_done); end
    checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", timeout); end
    checks++; if (t_rise !== 16'hFFFF || t_settle !== 16'hFFFF) begin failures++; $display("FAIL to_times got=%h/%h exp=ffff/ffff", t_rise, t_settle); end
    checks++; if (peak !== 16'd0 || overshoot !== 17'd0) begin failures++; $display("FAIL to_peak got=%0d/%0d exp=0/0", peak, overshoot); end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    fill_ramp();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < 11; k++) begin in_valid = 1; v_in = 16'(smp[k]); @(negedge clk); end
    in_valid = 0;
    #1 rst_n = 0;
    #1;
    checks++;
    if ({busy, done, timeout, t_rise, t_settle, peak, overshoot} !== '0) begin
      failures++; $display("FAIL rstmid_outputs got=%h exp=0", {busy, done, timeout, t_rise, t_settle, peak, overshoot});
    end
    @(negedge clk); rst_n = 1;
    saw_done = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1; v_in = 16'd1000; @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    in_valid = 0;
    checks++; if (saw_done) begin failures++; $display("FAIL rstmid_resume got=busy_or_done exp=idle"); end
  endtask

  task automatic test_restart();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int k = 0; k < 4; k++) begin in_valid = 1; v_in = 16'(100 * k); @(negedge clk); end
    in_valid = 0;
    test_ramp("restart", 0, 0);
  endtask

  task automatic test_random();
    int e, lo, hi, st, pk, r, nz, osa, ks, d;
    bit to;
    for (int it = 0; it < 20; it++) begin
      r = $urandom_range(60, 400); nz = $urandom_range(0, 40); osa = $urandom_range(0, 300);
      ks = 1000 / r;
      for (int k = 0; k < MAXC; k++) begin
        if (k * r < 1000) smp[k] = k * r;
        else begin
          d = k - ks; if (d > 30) d = 30;
          smp[k] = 1000 + (osa >>> d) + int'($urandom_range(0, 2 * nz)) - nz;
        end
      end
      model(e, lo, hi, st, to, pk);
      run(it % 3, it % 2 == 1);
      checks++; if (acc_done != e + 1) begin failures++; $display("FAIL rnd%0d_done_at got=%0d exp=%0d", it, acc_done, e + 1); end
      checks++; if (timeout !== to) begin failures++; $display("FAIL rnd%0d_timeout got=%b exp=%b", it, timeout, to); end
      checks++; if (int'(t_rise) != (to ? 65535 : hi - lo)) begin failures++; $display("FAIL rnd%0d_t_rise got=%0d exp=%0d", it, t_rise, to ? 65535 : hi - lo); end
      checks++; if (int'(t_settle) != (to ? 65535 : st)) begin failures++; $display("FAIL rnd%0d_t_settle got=%0d exp=%0d", it, t_settle, to ? 65535 : st); end
      checks++; if (int'($signed(peak)) != pk) begin failures++; $display("FAIL rnd%0d_peak got=%0d exp=%0d", it, $signed(peak), pk); end
      checks++; if (int'(overshoot) != (pk > VF ? pk - VF : 0)) begin failures++; $display("FAIL rnd%0d_overshoot got=%0d exp=%0d", it, overshoot, pk > VF ? pk - VF : 0); end
    end
  endtask

  initial begin
    test_reset();
    test_ramp("ramp", 0, 0);
    test_overshoot();
    test_band_reentry();
    test_timeout();
    test_ramp("gaps", 1, 1);
    test_reset_mid();
    test_restart();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/step_response_monitor.md
# step_response_monitor

Downstream measurement stage for the filter emulation bench. It consumes the filter's fixed-point output sample stream after a step is applied. It then reports rise time (low-to-high threshold crossing), peak value, overshoot and settling time as registered results that the emulation control logic can probe. All arithmetic is signed fixed-point at the same scale as the monitored signal.

## Interface
- WIDTH, 18: bit width of the signed fixed-point sample, final-value and threshold inputs.
- CNT_W, 16: width of the sample-index counter and of the time results.
- SETTLE_HOLD, 16: number of consecutive in-band samples required to declare settling (≥1).
- MAX_CYCLES, 65535: sample-index limit for timeout (≤ 2^CNT_W − 1).

Ports:
- clk  in  1  emulator clock; everything is on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse marking the step application; begins a measurement.
- in_valid  in  1  v_in carries a new sample this cycle.
- v_in  in  WIDTH  signed filter output sample.
- v_final  in  WIDTH  signed expected final value; held stable during a measurement.
- th_lo  in  WIDTH  signed low crossing threshold (e.g. 10 %).
- th_hi  in  WIDTH  signed high crossing threshold (e.g. 90 %); th_hi ≥ th_lo.
- band  in  WIDTH−1  unsigned settling half-band.
- busy  out  1  measurement in progress.
- done  out  1  one-cycle pulse when results become valid.
- timeout  out  1  last measurement hit MAX_CYCLES before settling.
- t_rise  out  CNT_W  t_hi_idx − t_lo_idx.
- t_settle  out  CNT_W  index of first sample of the qualifying in-band run.
- peak  out  WIDTH  maximum sample seen during the measurement.
- overshoot  out  WIDTH+1  max(peak − v_final, 0).

## Operation
- States:
  - IDLE: reset state.
  - WAIT_LO.
  - WAIT_HI.
  - SETTLE.
  - FINISH: results held.
- Transition into a measurement:
  - start in any state → WAIT_LO. Clears idx, run_len and run_start. Sets peak to the most negative value.
  - Results are zeroed. busy = 1.
  - start mid-measurement aborts and restarts.
- Sample accounting:
  - A sample is accepted when in_valid = 1 in WAIT_LO, WAIT_HI or SETTLE and start = 0.
  - start with in_valid in the same cycle: the sample is discarded.
  - idx = 0 for the first accepted sample and increments by 1 per accepted sample. Invalid cycles do not advance it.
- Peak: every accepted sample updates peak = max(peak, v_in).
- Crossing detection:
  - WAIT_LO: v_in ≥ th_lo records t_lo_idx = idx.
    - If v_in ≥ th_hi on the same sample, it also records t_hi_idx and goes to SETTLE.
    - Otherwise it goes to WAIT_HI.
  - WAIT_HI: v_in ≥ th_hi records t_hi_idx and goes to SETTLE.
- Settling check:
  - The crossing sample itself is evaluated for settling.
  - SETTLE: a sample is in band when |v_in − v_final| ≤ band, computed at WIDTH+1 bits with no wrap.
  - An in-band sample with run_len = 0 sets run_start = idx. Every in-band sample increments run_len.
  - An out-of-band sample clears run_len.
  - When run_len reaches SETTLE_HOLD: t_settle = run_start, t_rise = t_hi_idx − t_lo_idx, overshoot computed, then FINISH.
- Timeout:
  - An accepted sample with idx = MAX_CYCLES − 1 that does not complete settling → FINISH with timeout = 1.
  - t_rise and t_settle saturate to all-ones; peak and overshoot are still reported.
- FINISH: busy = 0, outputs held until the next start or reset.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - busy, done, timeout = 0; t_rise, t_settle, overshoot = 0.
  - peak = 0.
- busy rises the cycle after start is sampled.
- done pulses, and all results update, on the cycle after the qualifying (or timeout) sample is accepted. Latency is 1 clk.
- done is exactly one cycle wide. busy falls in the same cycle done asserts.
- Reset deasserted mid-measurement: the block returns to IDLE and does not resume.
- idx never wraps, because the timeout fires first.

## Test plan
Parameters for all scenarios: WIDTH = 16, SETTLE_HOLD = 4, v_final = 1000, th_lo = 100, th_hi = 900, band = 20, in_valid = 1 unless stated.

1. Ramp:
   - Stimulus: samples 100·k clamped at 1000.
   - Response: t_lo = 1, t_hi = 9, t_rise = 8, t_settle = 10, peak = 1000, overshoot = 0.
   - done pulses one cycle after sample 13.
2. Overshoot:
   - Stimulus: 0, 500, 1100, 1050, 1010, 995, 1000, 1000.
   - Response: t_rise = 1, t_settle = 4, peak = 1100, overshoot = 100, done after sample 7.
3. Band re-entry:
   - Stimulus: 0, 950, 1000, 1000, 1000, 1030, 1000 ×4.
   - Response: run broken at idx 5; t_settle = 6, t_rise = 0 (both thresholds crossed at idx 1).
4. Timeout:
   - Stimulus: MAX_CYCLES = 64, constant 0.
   - Response: timeout = 1, t_rise = t_settle = 0xFFFF, peak = 0, overshoot = 0, done after sample 63.
5. Gaps and collision:
   - Stimulus: scenario 1 with in_valid low every other cycle, plus in_valid asserted during the start cycle.
   - Response: identical results to scenario 1; the start-cycle sample is ignored.
6. Reset and restart:
   - rst_n low during SETTLE → all outputs 0 immediately, busy = 0.
   - start during WAIT_HI → measurement restarts at idx 0, and results match a fresh run.
